ex_operand_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage directly upstream of the combinational ALU.
- Captures decoded op, source operands, immediate and shamt from decode, resolves bypasses from EX/MEM/WB, and presents stable `op`/`data_x`/`data_y`/`shamt` to the ALU.
- Consumes the ALU result back as the EX bypass source.
- Owns load-use hazard detection, stall (valid/ready) and flush.

---
 rtl/ex_operand_stage_pkg.sv | 24 ++
 rtl/ex_operand_stage_bypass_mux.sv | 59 +++++
 rtl/ex_operand_stage.sv | 138 +++++++++++++
 tb/tb_ex_operand_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU opcode encodings and the
// hard-wired zero register number.
package ex_operand_stage_pkg;

   localparam int ALU_OP_BIT = 4;

   typedef enum logic [ALU_OP_BIT-1:0] {
      ALU_OP_ADD  = 4'd0,
      ALU_OP_SUB  = 4'd1,
      ALU_OP_AND  = 4'd2,
      ALU_OP_OR   = 4'd3,
      ALU_OP_XOR  = 4'd4,
      ALU_OP_NOR  = 4'd5,
      ALU_OP_SLT  = 4'd6,
      ALU_OP_SLTU = 4'd7,
      ALU_OP_SLL  = 4'd8,
      ALU_OP_SRL  = 4'd9,
      ALU_OP_SRA  = 4'd10,
      ALU_OP_LUI  = 4'd11
   } alu_op_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ex_operand_stage_bypass_mux.sv
// Per-source operand resolver: picks the freshest value for one source register
// and flags a hazard. Build with EXOP_FORWARD_EN for the bypass network.
module ex_bypass_mux
   import ex_operand_stage_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int DATA_W     = 32
)(
   input  logic [REG_ADDR_W-1:0] addr,
   input  logic                  used,
   input  logic [DATA_W-1:0]     rf_data,
   input  logic                  ex_we,
   input  logic                  ex_load,
   input  logic [REG_ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0]     ex_data,
   input  logic                  mem_we,
   input  logic                  mem_load,
   input  logic [REG_ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0]     mem_data,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   output logic [DATA_W-1:0]     data,
   output logic                  hazard
);

   logic live;
   logic ex_hit;
   logic mem_hit;
   logic wb_hit;

   // Register zero is never a dependency, whatever the writers claim.
   assign live    = used && (addr != REG_ADDR_W'(REG_ZERO));
   assign ex_hit  = ex_we  && (ex_addr  == addr);
   assign mem_hit = mem_we && (mem_addr == addr);
   assign wb_hit  = wb_we  && (wb_addr  == addr);

`ifdef EXOP_FORWARD_EN
   always_comb begin
      data = rf_data;
      if (live && ex_hit && !ex_load) begin
         data = ex_data;
      end else if (live && mem_hit && !mem_load) begin
         data = mem_data;
      end else if (live && wb_hit) begin
         data = wb_data;
      end
   end

   assign hazard = live && ((ex_hit && ex_load) || (mem_hit && mem_load));
`else
   logic unused_fwd;

   assign data       = rf_data;
   assign hazard     = live && (ex_hit || mem_hit || wb_hit);
   assign unused_fwd = ^{ex_load, ex_data, mem_load, mem_data, wb_data};
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand bypass, load-use stall and flush,
// feeding the combinational ALU. EXOP_FORWARD_EN enables the bypass network.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int DATA_W     = 32,
   parameter int SHAMT_W    = 5
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ALU_OP_BIT-1:0] in_op,
   input  logic [REG_ADDR_W-1:0] in_rs_addr,
   input  logic [REG_ADDR_W-1:0] in_rt_addr,
   input  logic                  in_rs_used,
   input  logic                  in_rt_used,
   input  logic [DATA_W-1:0]     in_rs_data,
   input  logic [DATA_W-1:0]     in_rt_data,
   input  logic [DATA_W-1:0]     in_imm,
   input  logic                  in_use_imm,
   input  logic [SHAMT_W-1:0]    in_shamt,
   input  logic [REG_ADDR_W-1:0] in_rd_addr,
   input  logic                  in_reg_we,
   input  logic                  in_mem_read,
   input  logic                  flush,
   input  logic                  ex_ready,
   input  logic [DATA_W-1:0]     ex_res,
   input  logic                  mem_we,
   input  logic                  mem_load,
   input  logic [REG_ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0]     mem_data,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   output logic                  out_valid,
   output logic [ALU_OP_BIT-1:0] out_op,
   output logic [DATA_W-1:0]     out_data_x,
   output logic [DATA_W-1:0]     out_data_y,
   output logic [SHAMT_W-1:0]    out_shamt,
   output logic [REG_ADDR_W-1:0] out_rd_addr,
   output logic                  out_reg_we,
   output logic                  out_mem_read
);

   logic                  valid_reg;
   logic [ALU_OP_BIT-1:0] op_reg;
   logic [DATA_W-1:0]     data_x_reg;
   logic [DATA_W-1:0]     data_y_reg;
   logic [SHAMT_W-1:0]    shamt_reg;
   logic [REG_ADDR_W-1:0] rd_addr_reg;
   logic                  reg_we_reg;
   logic                  mem_read_reg;

   logic                  advance;
   logic                  hazard;
   logic                  ex_we;
   logic [1:0]            src_hazard;
   logic [REG_ADDR_W-1:0] src_addr [2];
   logic                  src_used [2];
   logic [DATA_W-1:0]     src_rf   [2];
   logic [DATA_W-1:0]     src_sel  [2];

   assign src_addr[0] = in_rs_addr;
   assign src_addr[1] = in_rt_addr;
   assign src_used[0] = in_rs_used;
   // An immediate operand replaces rt, so rt can never create a dependency then.
   assign src_used[1] = in_rt_used && !in_use_imm;
   assign src_rf[0]   = in_rs_data;
   assign src_rf[1]   = in_rt_data;
   assign ex_we       = valid_reg && reg_we_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         ex_bypass_mux #(
            .REG_ADDR_W (REG_ADDR_W),
            .DATA_W     (DATA_W)
         ) u_mux (
            .addr     (src_addr[gi]),
            .used     (src_used[gi]),
            .rf_data  (src_rf[gi]),
            .ex_we    (ex_we),
            .ex_load  (mem_read_reg),
            .ex_addr  (rd_addr_reg),
            .ex_data  (ex_res),
            .mem_we   (mem_we),
            .mem_load (mem_load),
            .mem_addr (mem_addr),
            .mem_data (mem_data),
            .wb_we    (wb_we),
            .wb_addr  (wb_addr),
            .wb_data  (wb_data),
            .data     (src_sel[gi]),
            .hazard   (src_hazard[gi])
         );
      end
   endgenerate

   assign hazard   = |src_hazard;
   assign advance  = !valid_reg || ex_ready;
   assign in_ready = advance && !hazard && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg    <= 1'b0;
         op_reg       <= '0;
         data_x_reg   <= '0;
         data_y_reg   <= '0;
         shamt_reg    <= '0;
         rd_addr_reg  <= '0;
         reg_we_reg   <= 1'b0;
         mem_read_reg <= 1'b0;
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (advance) begin
         // A hazard turns this slot into a bubble; the payload is then don't-care.
         valid_reg    <= in_valid && !hazard;
         op_reg       <= in_op;
         data_x_reg   <= src_sel[0];
         data_y_reg   <= in_use_imm ? in_imm : src_sel[1];
         shamt_reg    <= in_shamt;
         rd_addr_reg  <= in_rd_addr;
         reg_we_reg   <= in_reg_we;
         mem_read_reg <= in_mem_read;
      end
   end

   assign out_valid    = valid_reg;
   assign out_op       = op_reg;
   assign out_data_x   = data_x_reg;
   assign out_data_y   = data_y_reg;
   assign out_shamt    = shamt_reg;
   assign out_rd_addr  = rd_addr_reg;
   assign out_reg_we   = reg_we_reg;
   assign out_mem_read = mem_read_reg;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed table, multi-cycle sequences
// and random traffic against a behavioural model of the stage.
module tb_ex_operand_stage;
   import ex_operand_stage_pkg::*;

`ifdef EXOP_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic                  clk;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [ALU_OP_BIT-1:0] in_op;
   logic [4:0]            in_rs_addr, in_rt_addr, in_rd_addr, in_shamt;
   logic                  in_rs_used, in_rt_used, in_use_imm, in_reg_we, in_mem_read;
   logic [31:0]           in_rs_data, in_rt_data, in_imm;
   logic                  flush, ex_ready;
   logic [31:0]           ex_res;
   logic                  mem_we, mem_load, wb_we;
   logic [4:0]            mem_addr, wb_addr;
   logic [31:0]           mem_data, wb_data;
   logic                  out_valid;
   logic [ALU_OP_BIT-1:0] out_op;
   logic [31:0]           out_data_x, out_data_y;
   logic [4:0]            out_shamt, out_rd_addr;
   logic                  out_reg_we, out_mem_read;

   int compared   = 0;
   int mismatched = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ex_operand_stage #(.REG_ADDR_W(5), .DATA_W(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rs_used(in_rs_used),
      .in_rt_used(in_rt_used), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm), .in_shamt(in_shamt),
      .in_rd_addr(in_rd_addr), .in_reg_we(in_reg_we), .in_mem_read(in_mem_read),
      .flush(flush), .ex_ready(ex_ready), .ex_res(ex_res), .mem_we(mem_we),
      .mem_load(mem_load), .mem_addr(mem_addr), .mem_data(mem_data), .wb_we(wb_we),
      .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid), .out_op(out_op),
      .out_data_x(out_data_x), .out_data_y(out_data_y), .out_shamt(out_shamt),
      .out_rd_addr(out_rd_addr), .out_reg_we(out_reg_we), .out_mem_read(out_mem_read)
   );

   typedef struct {
      logic valid; logic [ALU_OP_BIT-1:0] op;
      logic [4:0] rs, rt, rd, shamt; logic rs_used, rt_used, use_imm, reg_we, mem_read;
      logic [31:0] rs_data, rt_data, imm;
      logic flush, ex_ready; logic [31:0] ex_res;
      logic mem_we, mem_load; logic [4:0] mem_addr; logic [31:0] mem_data;
      logic wb_we; logic [4:0] wb_addr; logic [31:0] wb_data;
   } stim_t;

   typedef struct {
      logic valid; logic [ALU_OP_BIT-1:0] op; logic [31:0] x, y;
      logic [4:0] shamt, rd; logic we, mr;
   } held_t;

   typedef struct {
      stim_t prime; stim_t inc; logic rdy; logic v; logic [31:0] x, y;
   } row_t;

   held_t mh;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic stim_t nop();
      stim_t s;
      s = '{default: '0};
      s.ex_ready = 1'b1;
      return s;
   endfunction

   function automatic stim_t mk(input logic [ALU_OP_BIT-1:0] op, input logic [4:0] rs,
                                input logic [31:0] rsd, input logic [4:0] rt,
                                input logic [31:0] rtd, input logic [4:0] rd);
      stim_t s;
      s = nop();
      s.valid = 1'b1; s.op = op; s.rs = rs; s.rs_data = rsd; s.rt = rt; s.rt_data = rtd;
      s.rs_used = 1'b1; s.rt_used = 1'b1; s.rd = rd; s.reg_we = 1'b1; s.shamt = 5'd3;
      return s;
   endfunction

   // Value/hazard of one source: writers listed youngest first, first usable one wins.
   function automatic logic [32:0] resolve(input stim_t s, input held_t h, input logic [4:0] a,
                                           input logic live, input logic [31:0] rf);
      logic        w_on[3], w_load[3];
      logic [4:0]  w_addr[3];
      logic [31:0] w_data[3];
      logic        hz, got;
      logic [31:0] v;
      w_on[0] = h.valid && h.we; w_load[0] = h.mr;       w_addr[0] = h.rd;      w_data[0] = s.ex_res;
      w_on[1] = s.mem_we;        w_load[1] = s.mem_load; w_addr[1] = s.mem_addr; w_data[1] = s.mem_data;
      w_on[2] = s.wb_we;         w_load[2] = 1'b0;       w_addr[2] = s.wb_addr;  w_data[2] = s.wb_data;
      hz = 1'b0; got = 1'b0; v = rf;
      if (live && a != 5'd0) begin
         for (int i = 0; i < 3; i++) begin
            if (w_on[i] && w_addr[i] == a) begin
               if (!FWD || w_load[i]) hz = 1'b1;
               else if (!got) begin v = w_data[i]; got = 1'b1; end
            end
         end
      end
      return {hz, v};
   endfunction

   task automatic drive(input stim_t s);
      in_valid = s.valid; in_op = s.op; in_rs_addr = s.rs; in_rt_addr = s.rt;
      in_rs_used = s.rs_used; in_rt_used = s.rt_used; in_rs_data = s.rs_data;
      in_rt_data = s.rt_data; in_imm = s.imm; in_use_imm = s.use_imm; in_shamt = s.shamt;
      in_rd_addr = s.rd; in_reg_we = s.reg_we; in_mem_read = s.mem_read;
      flush = s.flush; ex_ready = s.ex_ready; ex_res = s.ex_res;
      mem_we = s.mem_we; mem_load = s.mem_load; mem_addr = s.mem_addr; mem_data = s.mem_data;
      wb_we = s.wb_we; wb_addr = s.wb_addr; wb_data = s.wb_data;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".valid"}, 32'(out_valid), 32'(mh.valid));
      if (mh.valid) begin
         chk({tag, ".op"}, 32'(out_op), 32'(mh.op));
         chk({tag, ".x"}, out_data_x, mh.x);
         chk({tag, ".y"}, out_data_y, mh.y);
         chk({tag, ".shamt"}, 32'(out_shamt), 32'(mh.shamt));
         chk({tag, ".rd"}, 32'(out_rd_addr), 32'(mh.rd));
         chk({tag, ".we"}, 32'(out_reg_we), 32'(mh.we));
         chk({tag, ".mr"}, 32'(out_mem_read), 32'(mh.mr));
      end
   endtask

   // One clock: drive at the falling edge, check in_ready, clock, check outputs.
   task automatic cycle(input stim_t s, input string tag, output logic rdy_seen);
      logic [32:0] rs_r, rt_r;
      logic        hz, adv, exp_rdy;
      held_t       nh;
      drive(s);
      #2;
      rs_r = resolve(s, mh, s.rs, s.rs_used, s.rs_data);
      rt_r = resolve(s, mh, s.rt, s.rt_used && !s.use_imm, s.rt_data);
      hz = rs_r[32] | rt_r[32];
      adv = !mh.valid || s.ex_ready;
      exp_rdy = adv && !hz && !s.flush;
      rdy_seen = in_ready;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
      nh = mh;
      if (s.flush) nh.valid = 1'b0;
      else if (adv) begin
         nh.valid = s.valid && !hz; nh.op = s.op; nh.x = rs_r[31:0];
         nh.y = s.use_imm ? s.imm : rt_r[31:0]; nh.shamt = s.shamt; nh.rd = s.rd;
         nh.we = s.reg_we; nh.mr = s.mem_read;
      end
      @(posedge clk);
      #1;
      mh = nh;
      check_outputs(tag);
      $display("cyc %s: in_valid=%0d in_ready=%0d out_valid=%0d x=%h y=%h",
               tag, s.valid, rdy_seen, out_valid, out_data_x, out_data_y);
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      drive(nop());
      @(posedge clk);
      #1;
      rst = 1'b0;
      mh = '{default: '0};
      chk({tag, ".valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".op"}, 32'(out_op), 32'(ALU_OP_ADD));
      chk({tag, ".x"}, out_data_x, 32'd0);
      chk({tag, ".y"}, out_data_y, 32'd0);
      chk({tag, ".shamt"}, 32'(out_shamt), 32'd0);
      chk({tag, ".rd"}, 32'(out_rd_addr), 32'd0);
      chk({tag, ".we"}, 32'(out_reg_we), 32'd0);
      chk({tag, ".mr"}, 32'(out_mem_read), 32'd0);
      $display("rst %s: outputs cleared", tag);
      @(negedge clk);
   endtask

   function automatic stim_t rnd_stim();
      stim_t s;
      s = nop();
      s.valid = ($urandom_range(0, 3) != 0);
      s.op = ALU_OP_BIT'($urandom_range(0, 11));
      s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7));
      s.rd = 5'($urandom_range(0, 7)); s.shamt = 5'($urandom);
      s.rs_used = $urandom_range(0, 1); s.rt_used = $urandom_range(0, 1);
      s.use_imm = $urandom_range(0, 1); s.reg_we = $urandom_range(0, 1);
      s.mem_read = ($urandom_range(0, 3) == 0);
      s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom; s.ex_res = $urandom;
      s.flush = ($urandom_range(0, 15) == 0); s.ex_ready = ($urandom_range(0, 3) != 0);
      s.mem_we = $urandom_range(0, 1); s.mem_load = $urandom_range(0, 1);
      s.mem_addr = 5'($urandom_range(0, 7)); s.mem_data = $urandom;
      s.wb_we = $urandom_range(0, 1); s.wb_addr = 5'($urandom_range(0, 7)); s.wb_data = $urandom;
      return s;
   endfunction

   initial begin
      row_t  tbl[10];
      stim_t alu_a, lw, s;
      logic  r;

      alu_a = mk(ALU_OP_ADD, 5'd3, 32'd5, 5'd4, 32'd7, 5'd8);
      lw = mk(ALU_OP_ADD, 5'd1, 32'h100, 5'd0, 32'd0, 5'd5);
      lw.mem_read = 1'b1; lw.rt_used = 1'b0;

      tbl[0] = '{nop(), alu_a, 1'b1, 1'b1, 32'd5, 32'd7};
      s = mk(ALU_OP_SUB, 5'd8, 32'hDEAD, 5'd0, 32'd0, 5'd9);
      s.rt_used = 1'b0; s.use_imm = 1'b1; s.imm = 32'h20; s.ex_res = 32'h10;
      tbl[1] = '{alu_a, s, FWD, FWD, 32'h10, 32'h20};
      s = mk(ALU_OP_OR, 5'd9, 32'h99, 5'd2, 32'h33, 5'd10);
      s.mem_we = 1'b1; s.mem_addr = 5'd9; s.mem_data = 32'd1;
      s.wb_we = 1'b1; s.wb_addr = 5'd9; s.wb_data = 32'd2;
      tbl[2] = '{nop(), s, FWD, FWD, 32'd1, 32'h33};
      s = mk(ALU_OP_AND, 5'd0, 32'd0, 5'd0, 32'd0, 5'd10);
      s.wb_we = 1'b1; s.wb_addr = 5'd0; s.wb_data = 32'd2;
      tbl[3] = '{nop(), s, 1'b1, 1'b1, 32'd0, 32'd0};
      tbl[4] = '{lw, mk(ALU_OP_XOR, 5'd1, 32'h11, 5'd5, 32'h55, 5'd12), 1'b0, 1'b0, 32'd0, 32'd0};
      s = mk(ALU_OP_ADD, 5'd1, 32'h11, 5'd5, 32'h55, 5'd12);
      s.rt_used = 1'b0; s.use_imm = 1'b1; s.imm = 32'h40;
      tbl[5] = '{lw, s, 1'b1, 1'b1, 32'h11, 32'h40};
      s = mk(ALU_OP_SLT, 5'd6, 32'h66, 5'd2, 32'h22, 5'd10);
      s.mem_we = 1'b1; s.mem_load = 1'b1; s.mem_addr = 5'd6;
      tbl[6] = '{nop(), s, 1'b0, 1'b0, 32'd0, 32'd0};
      s = mk(ALU_OP_SLL, 5'd7, 32'h70, 5'd2, 32'h22, 5'd11);
      s.wb_we = 1'b1; s.wb_addr = 5'd7; s.wb_data = 32'h77;
      tbl[7] = '{nop(), s, FWD, FWD, 32'h77, 32'h22};
      s = mk(ALU_OP_SUB, 5'd1, 32'h11, 5'd2, 32'h22, 5'd13);
      s.ex_ready = 1'b0;
      tbl[8] = '{alu_a, s, 1'b0, 1'b1, 32'd5, 32'd7};
      s = mk(ALU_OP_SUB, 5'd1, 32'h11, 5'd2, 32'h22, 5'd13);
      s.flush = 1'b1;
      tbl[9] = '{alu_a, s, 1'b0, 1'b0, 32'd0, 32'd0};

      rst = 1'b1;
      drive(nop());
      @(negedge clk);
      do_reset("reset");

      for (int i = 0; i < 10; i++) begin
         do_reset($sformatf("row%0d.rst", i));
         cycle(tbl[i].prime, $sformatf("row%0d.prime", i), r);
         cycle(tbl[i].inc, $sformatf("row%0d", i), r);
         chk($sformatf("row%0d.tbl_rdy", i), 32'(r), 32'(tbl[i].rdy));
         chk($sformatf("row%0d.tbl_valid", i), 32'(out_valid), 32'(tbl[i].v));
         if (tbl[i].v) begin
            chk($sformatf("row%0d.tbl_x", i), out_data_x, tbl[i].x);
            chk($sformatf("row%0d.tbl_y", i), out_data_y, tbl[i].y);
         end
      end

      // Load-use walk: load held, then in MEM, then in WB.
      do_reset("lu.rst");
      cycle(lw, "lu.load", r);
      s = mk(ALU_OP_ADD, 5'd2, 32'h22, 5'd5, 32'h55, 5'd14);
      cycle(s, "lu.held", r);
      chk("lu.held_rdy", 32'(r), 32'd0);
      chk("lu.bubble", 32'(out_valid), 32'd0);
      s.mem_we = 1'b1; s.mem_load = 1'b1; s.mem_addr = 5'd5;
      cycle(s, "lu.mem", r);
      chk("lu.mem_rdy", 32'(r), 32'd0);
      s.mem_we = 1'b0; s.wb_we = 1'b1; s.wb_addr = 5'd5; s.wb_data = 32'hABC;
      cycle(s, "lu.wb", r);
      chk("lu.wb_rdy", 32'(r), 32'(FWD));
      s.wb_we = 1'b0;
      cycle(s, "lu.clear", r);

      // Two-cycle downstream stall, then reset while holding.
      do_reset("st.rst");
      cycle(alu_a, "st.prime", r);
      s = mk(ALU_OP_OR, 5'd1, 32'h11, 5'd2, 32'h22, 5'd15);
      s.ex_ready = 1'b0;
      cycle(s, "st.hold0", r);
      cycle(s, "st.hold1", r);
      chk("st.hold_x", out_data_x, 32'd5);
      do_reset("st.rst_mid_hold");

      for (int i = 0; i < 400; i++) begin
         cycle(rnd_stim(), $sformatf("rnd%0d", i), r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
